// File: rtl/op_nub_update_if.sv
// Output-neuron-update bus: sequencer handshake plus the current-buffer read port.
// The master side is the sequencer/buffer; the slave side is op_nub_update.
interface op_nub_update_if #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 4,
  parameter int V_WIDTH     = 16
);
  logic                      start_op_nub;
  logic                      clear_img;
  logic                      cur_rd;
  logic [ADDR_W-1:0]         cur_addr;
  logic signed [V_WIDTH-1:0] cur_data;
  logic                      valid_op_nub;
  logic                      busy;
  logic [NUM_NEURONS-1:0]    spike_vec;
  logic [15:0]               spike_total;

  modport master (
    output start_op_nub, clear_img, cur_data,
    input  cur_rd, cur_addr, valid_op_nub, busy, spike_vec, spike_total
  );

  modport slave (
    input  start_op_nub, clear_img, cur_data,
    output cur_rd, cur_addr, valid_op_nub, busy, spike_vec, spike_total
  );
endinterface

// File: rtl/op_nub_update.sv
// Output-neuron update: sweeps every neuron once per start pulse (leak, integrate, saturate, fire).
// Optional per-neuron refractory counters are enabled with the REFRACTORY_EN macro.
module op_nub_update #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 4,
  parameter int V_WIDTH     = 16,
  parameter int THRESH      = 100,
  parameter int V_RESET     = 0,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRAC_TU   = 2
) (
  input  logic           clk,
  input  logic           rst,
  op_nub_update_if.slave nub
);
  typedef enum logic [1:0] {IDLE, FETCH, INTEG, DONE} state_t;

  localparam int                       EW       = V_WIDTH + 2;
  localparam logic signed [V_WIDTH-1:0] THR_V    = V_WIDTH'(THRESH);
  localparam logic signed [V_WIDTH-1:0] VRST_V   = V_WIDTH'(V_RESET);
  localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic signed [EW-1:0]     SAT_MAX  = {3'b000, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0]     SAT_MIN  = {3'b111, {(V_WIDTH-1){1'b0}}};

  state_t                    state_q;
  logic [ADDR_W-1:0]         idx_q;
  logic                      cur_rd_q;
  logic [ADDR_W-1:0]         cur_addr_q;
  logic                      valid_q;
  logic                      busy_q;
  logic [NUM_NEURONS-1:0]    spike_vec_q;
  logic [15:0]               spike_total_q;
  logic                      clr_pend_q;

  logic signed [V_WIDTH-1:0] v_all [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]    sel_vec;
  logic signed [V_WIDTH-1:0] v_cur;
  logic signed [V_WIDTH-1:0] leak_d;
  logic signed [EW-1:0]      t_d;
  logic signed [V_WIDTH-1:0] sat_d;
  logic                      refrac_d;
  logic                      fire_d;
  logic                      integ_d;
  logic                      clear_d;

`ifdef REFRACTORY_EN
  localparam int RC_W = (REFRAC_TU < 1) ? 1 : $clog2(REFRAC_TU + 1);
  logic [RC_W-1:0] rc_all [NUM_NEURONS];
  logic [RC_W-1:0] rc_cur;
`endif

  always_comb begin
    v_cur = VRST_V;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx_q == ADDR_W'(i)) v_cur = v_all[i];
    end
`ifdef REFRACTORY_EN
    rc_cur = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx_q == ADDR_W'(i)) rc_cur = rc_all[i];
    end
    refrac_d = (rc_cur != '0);
`else
    refrac_d = 1'b0;
`endif
    leak_d = v_cur >>> LEAK_SHIFT;
    t_d = $signed({{2{v_cur[V_WIDTH-1]}}, v_cur})
        - $signed({{2{leak_d[V_WIDTH-1]}}, leak_d})
        + $signed({{2{nub.cur_data[V_WIDTH-1]}}, nub.cur_data});
    if (t_d > SAT_MAX)      sat_d = {1'b0, {(V_WIDTH-1){1'b1}}};
    else if (t_d < SAT_MIN) sat_d = {1'b1, {(V_WIDTH-1){1'b0}}};
    else                    sat_d = t_d[V_WIDTH-1:0];
    integ_d = (state_q == INTEG);
    fire_d  = integ_d && !refrac_d && (sat_d >= THR_V);
    // A clear that arrives mid-sweep is held and applied on the DONE edge.
    clear_d = ((state_q == IDLE) && nub.clear_img)
           || ((state_q == DONE) && (clr_pend_q || nub.clear_img));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neu
      logic signed [V_WIDTH-1:0] v_q;
      logic                      sel;
      assign sel         = (idx_q == ADDR_W'(gi));
      assign sel_vec[gi] = sel;
      assign v_all[gi]   = v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  v_q <= VRST_V;
        else if (clear_d)         v_q <= VRST_V;
        else if (integ_d && sel)  v_q <= (fire_d || refrac_d) ? VRST_V : sat_d;
      end

`ifdef REFRACTORY_EN
      logic [RC_W-1:0] rc_q;
      assign rc_all[gi] = rc_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rc_q <= '0;
        else if (clear_d)         rc_q <= '0;
        else if (integ_d && sel) begin
          if (refrac_d)           rc_q <= rc_q - RC_W'(1);
          else if (fire_d)        rc_q <= RC_W'(REFRAC_TU);
        end
      end
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_rd_q      <= 1'b0;
      cur_addr_q    <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      spike_vec_q   <= '0;
      spike_total_q <= '0;
      clr_pend_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_pend_q <= 1'b0;
          if (nub.clear_img) spike_total_q <= '0;
          if (nub.start_op_nub) begin
            state_q     <= FETCH;
            busy_q      <= 1'b1;
            spike_vec_q <= '0;
            idx_q       <= '0;
            cur_rd_q    <= 1'b1;
            cur_addr_q  <= '0;
          end
        end
        FETCH: begin
          if (nub.clear_img) clr_pend_q <= 1'b1;
          cur_rd_q <= 1'b0;
          state_q  <= INTEG;
        end
        INTEG: begin
          if (nub.clear_img) clr_pend_q <= 1'b1;
          if (fire_d) begin
            spike_vec_q <= spike_vec_q | sel_vec;
            if (spike_total_q != 16'hFFFF) spike_total_q <= spike_total_q + 16'd1;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            state_q    <= FETCH;
            idx_q      <= idx_q + ADDR_W'(1);
            cur_rd_q   <= 1'b1;
            cur_addr_q <= idx_q + ADDR_W'(1);
          end
        end
        DONE: begin
          if (clr_pend_q || nub.clear_img) spike_total_q <= '0;
          clr_pend_q <= 1'b0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          cur_rd_q <= 1'b0;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign nub.cur_rd       = cur_rd_q;
  assign nub.cur_addr     = cur_addr_q;
  assign nub.valid_op_nub = valid_q;
  assign nub.busy         = busy_q;
  assign nub.spike_vec    = spike_vec_q;
  assign nub.spike_total  = spike_total_q;
endmodule

// File: tb/tb_op_nub_update.sv
// Randomized scoreboard bench for op_nub_update against a per-time-unit neuron model.
module tb_op_nub_update;
  localparam int N = 4, AW = 4, VW = 16, THR = 100, LS = 3, VR = 0, RT = 2;
  localparam int VMAX = 32767, VMIN = -32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  op_nub_update_if #(.NUM_NEURONS(N), .ADDR_W(AW), .V_WIDTH(VW)) nub ();

  op_nub_update #(
    .NUM_NEURONS(N), .ADDR_W(AW), .V_WIDTH(VW), .THRESH(THR),
    .V_RESET(VR), .LEAK_SHIFT(LS), .REFRAC_TU(RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nub (nub)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cur_tab [N];
  int mv      [N];
  int mrc     [N];
  int mtot;
  logic [N-1:0] last_vec;
  int act_start = -1;

  typedef struct {
    int           start_cyc;
    logic [N-1:0] vec;
    int           tot;
  } exp_t;
  exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  // Leak is floor(v / 2^LS), i.e. rounding toward minus infinity.
  function automatic int leak_of(input int v);
    int d;
    d = 1 << LS;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i]  = VR;
      mrc[i] = 0;
    end
    mtot = 0;
  endtask

  task automatic model_sweep(output logic [N-1:0] vec);
    int t;
    vec = '0;
    for (int i = 0; i < N; i++) begin
`ifdef REFRACTORY_EN
      if (mrc[i] != 0) begin
        mrc[i]--;
        mv[i] = VR;
        continue;
      end
`endif
      t = mv[i] - leak_of(mv[i]) + cur_tab[i];
      if (t > VMAX) t = VMAX;
      if (t < VMIN) t = VMIN;
      if (t >= THR) begin
        mv[i]  = VR;
        vec[i] = 1'b1;
        mrc[i] = RT;
        if (mtot < 65535) mtot++;
      end else begin
        mv[i] = t;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cur_rd"},   {31'd0, nub.cur_rd}, 0);
    check({tag, "_cur_addr"}, {28'd0, nub.cur_addr}, 0);
    check({tag, "_valid"},    {31'd0, nub.valid_op_nub}, 0);
    check({tag, "_busy"},     {31'd0, nub.busy}, 0);
    check({tag, "_spike_vec"}, {28'd0, nub.spike_vec}, 0);
    check({tag, "_spike_tot"}, {16'd0, nub.spike_total}, 0);
  endtask

  // One time unit; offsets are cycles relative to the start cycle, -1 means unused.
  task automatic run_tu(input int clr_off, input int xs_off, input int rst_off);
    exp_t e;
    logic [N-1:0] vec;
    @(negedge clk);
    check("spike_vec_hold", {28'd0, nub.spike_vec}, {28'd0, last_vec});
    @(posedge clk); #1;
    nub.start_op_nub = 1'b1;
    nub.clear_img    = (clr_off == 0);
    act_start        = cyc;
    if (rst_off < 0) begin
      if (clr_off == 0) model_clear();
      model_sweep(vec);
      e.start_cyc = cyc;
      e.vec       = vec;
      e.tot       = mtot;
      sb_q.push_back(e);
      last_vec = vec;
      if (clr_off >= 1 && clr_off <= 2 * N + 1) model_clear();
    end
    for (int off = 1; off <= 2 * N + 3; off++) begin
      @(posedge clk); #1;
      nub.start_op_nub = (off == xs_off);
      nub.clear_img    = (off == clr_off);
      rst              = (off == rst_off);
      if (off == rst_off) begin
        act_start = -1;
        model_clear();
        last_vec = '0;
        @(negedge clk);
        check_all_zero("midsweep_rst");
      end
    end
    #1;
    nub.start_op_nub = 1'b0;
    nub.clear_img    = 1'b0;
    rst              = 1'b0;
    act_start        = -1;
  endtask

  // Current buffer: data appears the cycle after the read strobe.
  initial begin
    logic [AW-1:0] a;
    nub.cur_data = '0;
    forever begin
      @(negedge clk);
      if (nub.cur_rd && !rst) begin
        a = nub.cur_addr;
        @(posedge clk); #1;
        nub.cur_data = (int'(a) < N) ? VW'(cur_tab[a]) : '0;
      end
    end
  end

  initial begin
    exp_t e;
    int   d;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid) begin
          check("valid_one_cycle", {31'd0, nub.valid_op_nub}, 0);
          check("busy_after_done", {31'd0, nub.busy}, 0);
        end
        if (nub.cur_rd) begin
          if (act_start < 0) begin
            check("cur_rd_outside_sweep", 1, 0);
          end else begin
            d = cyc - act_start;
            check("cur_rd_phase", d % 2, 1);
            check("cur_addr", {28'd0, nub.cur_addr}, (d - 1) / 2);
          end
        end
        if (nub.valid_op_nub && !prev_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("valid_cycle", cyc - e.start_cyc, 2 * N + 1);
            check("busy_at_done", {31'd0, nub.busy}, 1);
            check("spike_vec", {28'd0, nub.spike_vec}, {28'd0, e.vec});
            check("spike_total", {16'd0, nub.spike_total}, e.tot);
          end
        end
        prev_valid = nub.valid_op_nub;
      end
    end
  end

  task automatic set_tab(input int c0, input int c1, input int c2, input int c3);
    cur_tab[0] = c0; cur_tab[1] = c1; cur_tab[2] = c2; cur_tab[3] = c3;
  endtask

  initial begin
    nub.start_op_nub = 1'b0;
    nub.clear_img    = 1'b0;
    rst              = 1'b1;
    last_vec         = '0;
    model_clear();
    set_tab(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_tu(-1, -1, -1);                         // all-zero currents
    set_tab(0, 0, 120, 0);   run_tu(-1, -1, -1); // single spike on neuron 2
    set_tab(60, 0, 0, 0);    run_tu(-1, -1, -1); // integrate, no spike
    run_tu(-1, -1, -1);                          // 60-7+60 crosses threshold
    set_tab(0, -32768, 0, 0); run_tu(-1, -1, -1);
    run_tu(-1, -1, -1);                          // negative clamp
    set_tab(50, 30, 90, 20); run_tu(-1, -1, -1);
    run_tu(-1, 4, -1);                           // late start ignored
    run_tu(5, 4, -1);                            // deferred clear
    @(negedge clk);
    check("spike_total_after_clear", {16'd0, nub.spike_total}, mtot);
    run_tu(-1, -1, -1);
    run_tu(-1, -1, 6);                           // reset mid-sweep
    set_tab(99, 101, 100, 40); run_tu(-1, -1, -1);
    set_tab(10, 10, 10, 10);   run_tu(0, -1, -1); // clear with start
    set_tab(0, 0, 0, 150);
    for (int k = 0; k < 4; k++) run_tu(-1, -1, -1);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       cur_tab[i] = VMAX;
          1:       cur_tab[i] = VMIN;
          default: cur_tab[i] = int'($urandom_range(0, 300)) - 150;
        endcase
      end
      case ($urandom_range(0, 7))
        0:       run_tu($urandom_range(0, 2 * N + 1), -1, -1);
        1:       run_tu(-1, $urandom_range(1, 2 * N), -1);
        default: run_tu(-1, -1, -1);
      endcase
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/op_nub_update.md
Name: op_nub_update

Overview:
- Responder side of the output-neuron-update handshake.
- Waits for a one-cycle start_op_nub pulse, then sweeps all output neurons:
  - fetches each neuron's accumulated input current from the ip_nub current buffer (1-cycle read latency),
  - applies leak, integration and saturation,
  - thresholds the result and fires a spike.
- Returns a one-cycle valid_op_nub pulse once the sweep completes.
- Membrane potentials persist across time units; clear_img (driven by done_core_img) resets them between images.

Parameters:
- NUM_NEURONS, 10, number of output neurons swept per time unit (≥1, ≤2^ADDR_W).
- ADDR_W, 4, width of cur_addr.
- V_WIDTH, 16, signed membrane-potential and input-current width.
- THRESH, 100, signed firing threshold; spike when v ≥ THRESH.
- V_RESET, 0, potential loaded after a spike, at reset and on clear.
- LEAK_SHIFT, 3, leak term = v >>> LEAK_SHIFT (arithmetic shift); must be ≥1.
- REFRAC_TU, 2, refractory length in time units (used only with the optional feature).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start_op_nub, in, 1, one-cycle start pulse from the time-unit sequencer.
- clear_img, in, 1, one-cycle pulse; reset all potentials to V_RESET.
- cur_rd, out, 1, current-buffer read strobe.
- cur_addr, out, ADDR_W, current-buffer read address (neuron index).
- cur_data, in, V_WIDTH, signed current; valid the cycle after cur_rd.
- valid_op_nub, out, 1, one-cycle completion pulse.
- busy, out, 1, high from the cycle after start acceptance through the DONE cycle.
- spike_vec, out, NUM_NEURONS, spikes produced this time unit.
- spike_total, out, 16, cumulative spikes since the last clear.

Behaviour:
- Reset (async, rst high):
  - state=IDLE.
  - All outputs 0: cur_rd, cur_addr, valid_op_nub, busy, spike_vec, spike_total.
  - Neuron index = 0; every v[i] = V_RESET.
  - A reset mid-sweep aborts the sweep; no valid_op_nub is issued.
- All outputs are registered.
- States:
  - IDLE: start_op_nub=1 → FETCH. On that edge: busy=1, spike_vec=0, idx=0, cur_rd=1, cur_addr=0.
  - FETCH (cur_rd high this cycle) → INTEG. On that edge cur_rd=0.
  - INTEG: cur_data is valid. Compute in V_WIDTH+2 bits:
    - t = v[idx] − (v[idx] >>> LEAK_SHIFT) + cur_data.
    - Saturate t to [−2^(V_WIDTH−1), 2^(V_WIDTH−1)−1].
    - If sat ≥ THRESH (signed): v[idx]=V_RESET, spike_vec[idx]=1, spike_total+=1 (saturates at 0xFFFF).
    - Else: v[idx]=sat.
    - If idx=NUM_NEURONS−1 → DONE.
    - Else → FETCH with idx+1, cur_rd=1, cur_addr=idx+1.
  - DONE: valid_op_nub high for exactly this cycle, busy high → IDLE. On that edge busy=0, valid_op_nub=0.
  - Undefined state → IDLE.
- Timing (start sampled in cycle 0):
  - Neuron i: FETCH in cycle 1+2i, INTEG in cycle 2+2i.
  - valid_op_nub in cycle 2·NUM_NEURONS+1.
  - Earliest next accepted start: cycle 2·NUM_NEURONS+2.
- start_op_nub while state≠IDLE: ignored, not queued.
- spike_vec holds its value from valid_op_nub until the next accepted start.
- clear_img:
  - In IDLE: all v=V_RESET and spike_total=0 on the next edge. clear_img wins over a simultaneous start; that start is still accepted.
  - While busy: latched as pending and applied on the DONE edge, after that sweep's updates. The pulse is still asserted normally.

Optional Feature:
- Macro: REFRACTORY_EN.
- Defined:
  - Each neuron gets a refractory counter rc[i], reset to 0.
  - On a spike, rc[i]=REFRAC_TU.
  - In INTEG with rc[idx]≠0: cur_data is discarded, v[idx] held at V_RESET, no spike, rc[idx] decremented.
  - The read still occurs, so timing is unchanged.
  - clear_img also zeroes all rc.
- Undefined: no counters; every neuron integrates every time unit.

Test Plan:
Configuration: NUM_NEURONS=4, THRESH=100, LEAK_SHIFT=3, V_RESET=0.
1. Reset, start with all cur_data=0 → cur_addr 0,1,2,3 with cur_rd in cycles 1,3,5,7; valid_op_nub in cycle 9 only; spike_vec=0000; spike_total=0.
2. cur_data=120 for neuron 2, 0 elsewhere → spike_vec=0100; spike_total=1; v[2]=0.
3. cur_data=60 to neuron 0 over two time units:
   - TU1: v=60, no spike.
   - TU2: 60−7+60=113 → spike_vec=0001, v[0]=0.
4. cur_data=−32768 to neuron 1 over two time units → v[1]=−32768 both times (second step clamps −61440); no spike, no wrap.
5. Mid-sweep events:
   - start pulse in cycle 4 → ignored; single valid in cycle 9.
   - clear_img in cycle 5 → all v=0 and spike_total=0 after cycle 9.
   - rst in cycle 6 → all outputs 0; no valid_op_nub.
6. REFRACTORY_EN, REFRAC_TU=2, cur_data=150 to neuron 3 every time unit → spike_vec[3]=1 in TU1, 0 in TU2 and TU3, 1 in TU4.
